// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the RV32I-subset multicycle controller:
// FSM states, ALU operation codes, opcodes and datapath mux selects.
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_WB_ALU,
      S_MEM_ADDR,
      S_MEM_RD,
      S_WB_MEM,
      S_MEM_WR,
      S_BRANCH,
      S_JAL,
      S_TRAP
   } state_t;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLTU = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] SRC_A_PC    = 2'b00;
   localparam logic [1:0] SRC_A_RS1   = 2'b01;
   localparam logic [1:0] SRC_A_OLDPC = 2'b10;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_FOUR = 2'b01;
   localparam logic [1:0] SRC_B_IMM  = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_if.sv
// Controller-to-datapath bundle: instruction/status inputs, memory request
// and datapath strobes. master = controller, slave = datapath/memory side.
interface multicycle_if;
   logic [31:0] instr;
   logic        alu_zero;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        iord;
   logic        ir_write;
   logic        pc_write;
   logic        pc_src;
   logic [1:0]  alu_src_a;
   logic [1:0]  alu_src_b;
   logic [3:0]  alu_op;
   logic        reg_write;
   logic [1:0]  result_src;

   modport master (
      input  instr, alu_zero, mem_ready,
      output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
             alu_src_a, alu_src_b, alu_op, reg_write, result_src
   );

   modport slave (
      output instr, alu_zero, mem_ready,
      input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
             alu_src_a, alu_src_b, alu_op, reg_write, result_src
   );
endinterface

// File: rtl/alu_op_decode.sv
// Maps funct3/funct7[5] to the 4-bit ALU code. SLT and SLTU swap low bits
// because the ALU numbers them opposite to the RV32I funct3 encoding.
module alu_op_decode
   import multicycle_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       is_rtype,
   output logic [3:0] alu_op
);

   logic [2:0] code_lo;
   logic       code_hi;

   always_comb begin
      code_lo = funct3;
      if (funct3 == 3'b010)
         code_lo = ALU_SLT[2:0];
      else if (funct3 == 3'b011)
         code_lo = ALU_SLTU[2:0];
      // immediates reuse bit 30 as data except for the shift-right pair
      code_hi = funct7_5 & (is_rtype | (funct3 == 3'b101));
      alu_op  = {code_hi, code_lo};
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset control unit with retired-instruction counter.
// Build option MULTICYCLE_TRAP_EN: illegal encodings park the FSM in TRAP.
//
// state      | meaning
// IDLE       | after reset, outputs quiet
// FETCH      | read instruction at PC, PC+4 into PC on mem_ready
// DECODE     | branch/jump target oldPC+imm into ALUOut, dispatch
// EXEC_R     | rs1 op rs2
// EXEC_I     | rs1 op imm
// WB_ALU     | ALUOut to rd, retire
// MEM_ADDR   | rs1+imm into ALUOut
// MEM_RD     | load request at ALUOut
// WB_MEM     | memory data to rd, retire
// MEM_WR     | store request at ALUOut, retire on mem_ready
// BRANCH     | compare rs1-rs2, ALUOut to PC if taken, retire
// JAL        | oldPC+4 to rd, ALUOut to PC, retire
// TRAP       | illegal encoding, hold until reset
module multicycle_ctrl
   import multicycle_pkg::*;
#(
   parameter int RETIRE_W = 32
)
(
   input  logic                clk,
   input  logic                rst_n,
   multicycle_if.master        bus,
   output logic [RETIRE_W-1:0] instr_retired,
   output logic                illegal
);

`ifdef MULTICYCLE_TRAP_EN
   localparam state_t ILLEGAL_NEXT = S_TRAP;
`else
   localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

   state_t     state;
   state_t     nxt_state;
   logic       retire;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       br_ok;
   logic       br_taken;
   logic [3:0] dec_op;
   logic       pc_write_q;

   logic       nxt_mem_req;
   logic       nxt_mem_we;
   logic       nxt_iord;
   logic       nxt_pc_src;
   logic       nxt_pc_write;
   logic [1:0] nxt_src_a;
   logic [1:0] nxt_src_b;
   logic [3:0] nxt_alu_op;
   logic       nxt_reg_write;
   logic [1:0] nxt_result_src;

   logic       unused_instr;

   assign opcode       = bus.instr[6:0];
   assign funct3       = bus.instr[14:12];
   assign br_ok        = (funct3 == 3'b000) || (funct3 == 3'b001);
   assign unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

   alu_op_decode u_alu_op_decode (
      .funct3   (funct3),
      .funct7_5 (bus.instr[30]),
      .is_rtype (opcode == OP_R),
      .alu_op   (dec_op)
   );

   always_comb begin
      nxt_state = state;
      retire    = 1'b0;
      case (state)
         S_IDLE:     nxt_state = S_FETCH;
         S_FETCH:    if (bus.mem_ready) nxt_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_R:              nxt_state = S_EXEC_R;
               OP_IMM:            nxt_state = S_EXEC_I;
               OP_LOAD, OP_STORE: nxt_state = S_MEM_ADDR;
               OP_BRANCH:         nxt_state = br_ok ? S_BRANCH : ILLEGAL_NEXT;
               OP_JAL:            nxt_state = S_JAL;
               default:           nxt_state = ILLEGAL_NEXT;
            endcase
         end
         S_EXEC_R,
         S_EXEC_I:   nxt_state = S_WB_ALU;
         S_MEM_ADDR: nxt_state = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (bus.mem_ready) nxt_state = S_WB_MEM;
         S_MEM_WR: begin
            if (bus.mem_ready) begin
               nxt_state = S_FETCH;
               retire    = 1'b1;
            end
         end
         S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: begin
            nxt_state = S_FETCH;
            retire    = 1'b1;
         end
         S_TRAP:     nxt_state = S_TRAP;
         default:    nxt_state = S_IDLE;
      endcase
   end

   // Outputs are registered, so decode them from the state being entered.
   always_comb begin
      nxt_mem_req    = 1'b0;
      nxt_mem_we     = 1'b0;
      nxt_iord       = 1'b0;
      nxt_pc_src     = 1'b0;
      nxt_pc_write   = 1'b0;
      nxt_src_a      = SRC_A_PC;
      nxt_src_b      = SRC_B_RS2;
      nxt_alu_op     = ALU_ADD;
      nxt_reg_write  = 1'b0;
      nxt_result_src = RES_ALUOUT;
      case (nxt_state)
         S_FETCH: begin
            nxt_mem_req = 1'b1;
            nxt_src_b   = SRC_B_FOUR;
         end
         S_DECODE: begin
            nxt_src_a = SRC_A_OLDPC;
            nxt_src_b = SRC_B_IMM;
         end
         S_EXEC_R: begin
            nxt_src_a  = SRC_A_RS1;
            nxt_alu_op = dec_op;
         end
         S_EXEC_I: begin
            nxt_src_a  = SRC_A_RS1;
            nxt_src_b  = SRC_B_IMM;
            nxt_alu_op = dec_op;
         end
         S_WB_ALU:   nxt_reg_write = 1'b1;
         S_MEM_ADDR: begin
            nxt_src_a = SRC_A_RS1;
            nxt_src_b = SRC_B_IMM;
         end
         S_MEM_RD: begin
            nxt_mem_req = 1'b1;
            nxt_iord    = 1'b1;
         end
         S_WB_MEM: begin
            nxt_reg_write  = 1'b1;
            nxt_result_src = RES_MEM;
         end
         S_MEM_WR: begin
            nxt_mem_req = 1'b1;
            nxt_mem_we  = 1'b1;
            nxt_iord    = 1'b1;
         end
         S_BRANCH: begin
            nxt_src_a  = SRC_A_RS1;
            nxt_alu_op = ALU_SUB;
            nxt_pc_src = 1'b1;
         end
         S_JAL: begin
            nxt_src_a      = SRC_A_OLDPC;
            nxt_src_b      = SRC_B_FOUR;
            nxt_reg_write  = 1'b1;
            nxt_result_src = RES_ALU;
            nxt_pc_write   = 1'b1;
            nxt_pc_src     = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         bus.mem_req    <= 1'b0;
         bus.mem_we     <= 1'b0;
         bus.iord       <= 1'b0;
         bus.pc_src     <= 1'b0;
         bus.alu_src_a  <= SRC_A_PC;
         bus.alu_src_b  <= SRC_B_RS2;
         bus.alu_op     <= ALU_ADD;
         bus.reg_write  <= 1'b0;
         bus.result_src <= RES_ALUOUT;
         pc_write_q     <= 1'b0;
         instr_retired  <= '0;
`ifdef MULTICYCLE_TRAP_EN
         illegal        <= 1'b0;
`endif
      end else begin
         state          <= nxt_state;
         bus.mem_req    <= nxt_mem_req;
         bus.mem_we     <= nxt_mem_we;
         bus.iord       <= nxt_iord;
         bus.pc_src     <= nxt_pc_src;
         bus.alu_src_a  <= nxt_src_a;
         bus.alu_src_b  <= nxt_src_b;
         bus.alu_op     <= nxt_alu_op;
         bus.reg_write  <= nxt_reg_write;
         bus.result_src <= nxt_result_src;
         pc_write_q     <= nxt_pc_write;
         if (retire)
            instr_retired <= instr_retired + RETIRE_W'(1);
`ifdef MULTICYCLE_TRAP_EN
         illegal        <= (nxt_state == S_TRAP);
`endif
      end
   end

`ifndef MULTICYCLE_TRAP_EN
   assign illegal = 1'b0;
`endif

   // Strobes that react to mem_ready/alu_zero within the same cycle.
   assign br_taken     = (state == S_BRANCH) &&
                         (((funct3 == 3'b000) && bus.alu_zero) ||
                          ((funct3 == 3'b001) && !bus.alu_zero));
   assign bus.ir_write = (state == S_FETCH) && bus.mem_ready;
   assign bus.pc_write = pc_write_q | bus.ir_write | br_taken;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit that issues ALU operation codes, operand selects, memory requests and register/PC write strobes for an RV32I subset, one instruction at a time. It is the initiator side of the 4-bit ALU operation interface. It sits between the instruction register and the shared datapath (PC, IR, register file, ALU, ALUOut register, memory port). It also counts retired instructions.

## Interface
- RETIRE_W, 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr  in  32  current IR contents (valid from DECODE onward)
- alu_zero  in  1  ALU result == 0 (combinational from datapath)
- mem_ready  in  1  memory completes the pending request this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  write request (qualifies mem_req)
- iord  out  1  address select: 0 PC, 1 ALUOut
- ir_write  out  1  load IR and oldPC
- pc_write  out  1  load PC
- pc_src  out  1  PC source: 0 ALU result, 1 ALUOut
- alu_src_a  out  2  00 PC, 01 rs1, 10 oldPC
- alu_src_b  out  2  00 rs2, 01 constant 4, 10 immediate
- alu_op  out  4  ALU operation code
- reg_write  out  1  register file write
- result_src  out  2  00 ALUOut, 01 memory data, 10 ALU result
- instr_retired  out  RETIRE_W  retired-instruction count
- illegal  out  1  trap flag (only with MULTICYCLE_TRAP_EN)

## Operation
- ALU codes: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLTU, 0011 SLT, 0100 XOR slot, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
- funct3 to code[2:0]: identity, except 010 maps to 011 and 011 maps to 010.
- R-type: code[3] = funct7[5]. I-type: code[3] = funct7[5] only when funct3 = 101; otherwise 0.
- Outputs are decoded from the state (plus funct/alu_zero where noted). Any strobe not listed for a state is 0, with alu_op = 0000.
- IDLE: all outputs 0. Next state FETCH.
- FETCH: mem_req, iord=0, a=PC, b=4, ADD.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: a=oldPC, b=imm, ADD (target into ALUOut). Next state by opcode:
  - 0110011 goes to EXEC_R.
  - 0010011 goes to EXEC_I.
  - 0000011 and 0100011 go to MEM_ADDR.
  - 1100011 goes to BRANCH.
  - 1101111 goes to JAL.
  - Any other opcode is illegal.
- EXEC_R: a=rs1, b=rs2, R-type code. Next WB_ALU.
- EXEC_I: a=rs1, b=imm, I-type code. Next WB_ALU.
- WB_ALU: reg_write, result_src=00. Next FETCH; retire.
- MEM_ADDR: a=rs1, b=imm, ADD. Next MEM_RD for load, MEM_WR for store.
- MEM_RD: mem_req, iord=1. Wait for mem_ready, then WB_MEM.
- WB_MEM: reg_write, result_src=01. Next FETCH; retire.
- MEM_WR: mem_req, mem_we, iord=1. Wait for mem_ready, then FETCH; retire.
- BRANCH: a=rs1, b=rs2, SUB, pc_src=1.
  - pc_write = (funct3==000 & alu_zero) | (funct3==001 & ~alu_zero).
  - Next FETCH; retire.
  - Any other funct3 is illegal.
- JAL: a=oldPC, b=4, ADD, reg_write, result_src=10, pc_write, pc_src=1. Next FETCH; retire.
- Retire means instr_retired increments by 1 on the leaving edge. The counter wraps from all-ones to 0.
- mem_ready is ignored whenever mem_req=0.

## Timing
- Reset (asserted at any time, including mid-request): state IDLE and all outputs 0 immediately. instr_retired = 0, illegal = 0.
- First FETCH occurs one cycle after rst_n deasserts.
- Cycles per instruction with zero-wait memory: R/I = 4, load = 5, store = 4, branch = 3, JAL = 3.
- Each wait cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_req, iord and mem_we stay stable for the whole request.
- The request completes in the cycle mem_ready = 1.

## Configuration
- MULTICYCLE_TRAP_EN defined:
  - An illegal opcode or branch funct3 enters TRAP.
  - In TRAP, illegal=1, all other strobes are 0, and the FSM holds until reset.
  - Nothing is retired.
- MULTICYCLE_TRAP_EN undefined:
  - An illegal encoding returns to FETCH with no writes and is not counted.
  - illegal is tied to 0.

## Structure
- Package multicycle_pkg holds:
  - the state enum
  - ALU code constants
  - opcode constants
  - alu_src_a, alu_src_b and result_src encodings
- Sub-module alu_op_decode: combinational, takes funct3, funct7[5] and an is_rtype flag, and produces the 4-bit code, including the SLT/SLTU swap.

## Test plan
- add x3,x1,x2 (0x002081B3), mem_ready always 1 → FETCH, DECODE, EXEC_R, WB_ALU; alu_op 0000 in EXEC_R; reg_write in cycle 4; instr_retired 0 → 1.
- sub/sra/slt/sltu/srai as R-type then I-type → alu_op 1000, 1101, 0011, 0010, 1101; addi with funct7[5]=1 → 0000.
- lw with mem_ready low 3 cycles in MEM_RD → mem_req and iord held 4 cycles; total 8 cycles; result_src=01 in WB_MEM.
- beq with alu_zero=1, then with alu_zero=0 → pc_write=1 with pc_src=1, then pc_write=0; 3 cycles each.
- rst_n pulled low mid-FETCH wait → mem_req drops the same cycle; IDLE; counter 0; FETCH one cycle after release.
- opcode 0x7F → with MULTICYCLE_TRAP_EN, illegal=1 held and no further mem_req; without it, back to FETCH after DECODE and counter unchanged.
